// File: rtl/exec_stage_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exec_stage_pipe_reg                                            |
// | Function : execute-to-memory pipeline register with valid/ready,         |
// |            two-entry skid buffer, synchronous flush and stall counter.   |
// | Option   : EXEC_STAGE_NEGEDGE_EN selects falling-edge register updates.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module exec_stage_pipe_reg #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] result_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [REG_AW-1:0] c_addr_in,
  input  logic              reg_write_in,
  input  logic              data_read_in,
  input  logic              data_write_in,
  input  logic              reg_addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_AW-1:0] c_addr,
  output logic              reg_write,
  output logic              data_read,
  output logic              data_write,
  output logic              reg_addr,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Payload layout: {result, addr, c_addr, reg_addr, reg_write, data_read, data_write}
  localparam int              c_PAY_W   = DATA_W + ADDR_W + REG_AW + 4;
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [c_PAY_W-1:0] r_head;
  logic [c_PAY_W-1:0] r_skid;
  logic               r_head_valid;
  logic               r_skid_valid;
  logic               r_in_ready;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic [c_PAY_W-1:0] w_in_pay;
  logic [c_PAY_W-1:0] w_head;
  logic [c_PAY_W-1:0] w_skid;
  logic               w_head_valid;
  logic               w_skid_valid;
  logic [CNT_W-1:0]   w_stall_cnt;
  logic               w_accept;
  logic               w_pop;

  assign w_in_pay = {result_in, addr_in, c_addr_in, reg_addr_in,
                     reg_write_in, data_read_in, data_write_in};
  assign w_accept = in_valid && r_in_ready;
  assign w_pop    = r_head_valid && out_ready;

  always_comb begin
    w_head       = r_head;
    w_skid       = r_skid;
    w_head_valid = r_head_valid;
    w_skid_valid = r_skid_valid;
    w_stall_cnt  = r_stall_cnt;

    if (r_head_valid && !out_ready && (r_stall_cnt != c_CNT_MAX))
      w_stall_cnt = r_stall_cnt + CNT_W'(1);

    if (flush) begin
      w_head_valid = 1'b0;
      w_skid_valid = 1'b0;
    end else if (!r_head_valid) begin
      if (w_accept) begin
        w_head       = w_in_pay;
        w_head_valid = 1'b1;
      end
    end else if (!r_skid_valid) begin
      if (w_accept && w_pop) begin
        w_head = w_in_pay;
      end else if (w_accept) begin
        w_skid       = w_in_pay;
        w_skid_valid = 1'b1;
      end else if (w_pop) begin
        w_head_valid = 1'b0;
      end
    end else if (w_pop) begin
      w_head       = r_skid;
      w_skid_valid = 1'b0;
    end

    // Control bits of an empty head are cleared so a bubble never writes.
    if (!w_head_valid)
      w_head[2:0] = 3'b000;
  end

  always_ff @(
`ifdef EXEC_STAGE_NEGEDGE_EN
    negedge CLK
`else
    posedge CLK
`endif
    or posedge RST) begin
    if (RST) begin
      r_head       <= '0;
      r_skid       <= '0;
      r_head_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_stall_cnt  <= '0;
    end else begin
      r_head       <= w_head;
      r_skid       <= w_skid;
      r_head_valid <= w_head_valid;
      r_skid_valid <= w_skid_valid;
      r_in_ready   <= !w_skid_valid;
      r_stall_cnt  <= w_stall_cnt;
    end
  end

  assign {result, addr, c_addr, reg_addr, reg_write, data_read, data_write} = r_head;
  assign out_valid = r_head_valid;
  assign in_ready  = r_in_ready;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exec_stage_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_exec_stage_pipe_reg                                         |
// | Function : scoreboard bench for exec_stage_pipe_reg against a FIFO model. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_exec_stage_pipe_reg;

  typedef struct packed {
    logic [15:0] result;
    logic [7:0]  addr;
    logic [3:0]  c_addr;
    logic        reg_addr;
    logic        reg_write;
    logic        data_read;
    logic        data_write;
  } pay_t;

`ifdef EXEC_STAGE_NEGEDGE_EN
  localparam bit c_NEG = 1'b1;
`else
  localparam bit c_NEG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  pay_t p_in = '0;

  logic        in_ready, out_valid;
  logic [15:0] result;
  logic [7:0]  addr;
  logic [3:0]  c_addr;
  logic        reg_write, data_read, data_write, reg_addr;
  logic [7:0]  stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [15:0] s_result;
  logic [7:0]  s_addr;
  logic [3:0]  s_c_addr;
  logic        s_reg_write, s_data_read, s_data_write, s_reg_addr;
  logic [2:0]  s_stall_cnt;

  pay_t p_out, s_p_out;
  logic act_clk;

  assign p_out   = {result, addr, c_addr, reg_addr, reg_write, data_read, data_write};
  assign s_p_out = {s_result, s_addr, s_c_addr, s_reg_addr, s_reg_write, s_data_read, s_data_write};
  assign act_clk = c_NEG ? ~clk : clk;

  always #5 clk = ~clk;

  exec_stage_pipe_reg u_dut (
    .CLK(clk), .RST(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .result_in(p_in.result), .addr_in(p_in.addr), .c_addr_in(p_in.c_addr),
    .reg_write_in(p_in.reg_write), .data_read_in(p_in.data_read),
    .data_write_in(p_in.data_write), .reg_addr_in(p_in.reg_addr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .addr(addr),
    .c_addr(c_addr), .reg_write(reg_write), .data_read(data_read),
    .data_write(data_write), .reg_addr(reg_addr), .stall_cnt(stall_cnt)
  );

  exec_stage_pipe_reg #(.CNT_W(3)) u_sat (
    .CLK(clk), .RST(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .result_in(p_in.result), .addr_in(p_in.addr), .c_addr_in(p_in.c_addr),
    .reg_write_in(p_in.reg_write), .data_read_in(p_in.data_read),
    .data_write_in(p_in.data_write), .reg_addr_in(p_in.reg_addr),
    .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result), .addr(s_addr),
    .c_addr(s_c_addr), .reg_write(s_reg_write), .data_read(s_data_read),
    .data_write(s_data_write), .reg_addr(s_reg_addr), .stall_cnt(s_stall_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_pop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of depth two; stall count saturates.
  pay_t mq[$];
  pay_t exp_q[$];
  pay_t last_head = '0;
  int   m_cnt8 = 0;
  int   m_cnt3 = 0;

  always @(posedge act_clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_cnt8 = 0;
      m_cnt3 = 0;
      last_head = '0;
    end else begin
      bit acc, pop;
      acc = in_valid && (mq.size() < 2);
      pop = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      if (flush) begin
        mq.delete();
        exp_q.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (acc) begin
          mq.push_back(p_in);
          exp_q.push_back(p_in);
        end
      end
      if (mq.size() > 0) last_head = mq[0];
    end
  end

  // Monitor: mid-cycle, away from the active edge.
  always @(negedge act_clk) begin
    pay_t e;
    if (mq.size() > 0) e = mq[0];
    else begin
      e = last_head;
      e.reg_write = 1'b0;
      e.data_read = 1'b0;
      e.data_write = 1'b0;
    end
    chk("out_valid", out_valid, mq.size() > 0);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("outputs", p_out, e);
    chk("stall_cnt", stall_cnt, m_cnt8);
    chk("sat_valid", s_out_valid, mq.size() > 0);
    chk("sat_outputs", s_p_out, e);
    chk("sat_stall_cnt", s_stall_cnt, m_cnt3);
    if (out_valid && out_ready && !flush && !rst) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got beat %0h expected none", p_out);
      end else begin
        pay_t x;
        x = exp_q.pop_front();
        chk("sb_order", p_out, x);
        n_pop++;
      end
    end
  end

  task automatic tick(output bit a);
    @(negedge act_clk);
    a = in_valid && in_ready;
    @(posedge act_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    int p0;
    acc = 1'b0;
    @(posedge act_clk);
    #1;
    tick(acc);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    tick(acc);
    rst = 1'b0;
    tick(acc);

    // Single beat
    p_in = '0;
    p_in.result = 16'h1234;
    p_in.addr = 8'h5A;
    p_in.c_addr = 4'd3;
    p_in.reg_write = 1'b1;
    in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_result", result, 16'h1234);
    chk("single_addr", addr, 8'h5A);
    chk("single_c_addr", c_addr, 3);
    chk("single_reg_write", reg_write, 1);
    tick(acc);
    chk("single_bubble_valid", out_valid, 0);
    chk("single_bubble_reg_write", reg_write, 0);
    chk("single_hold_result", result, 16'h1234);

    // Streaming
    p0 = n_pop;
    for (int i = 1; i <= 8; i++) begin
      p_in = '0;
      p_in.result = 16'(i);
      in_valid = 1'b1;
      tick(acc);
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick(acc);
    tick(acc);
    chk("stream_count", n_pop - p0, 8);
    chk("stream_stall", stall_cnt, 0);

    // Backpressure
    p0 = n_pop;
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      p_in = '0;
      p_in.result = 16'(i);
      in_valid = 1'b1;
      tick(acc);
      if (i < 3) chk("bp_accept", acc, 1);
    end
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_beat3_held", acc, 0);
    tick(acc);
    tick(acc);
    chk("bp_stall_cnt", stall_cnt, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && !acc; k++) tick(acc);
    chk("bp_beat3_accepted", acc, 1);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick(acc);
    chk("bp_count", n_pop - p0, 3);
    chk("bp_stall_final", stall_cnt, 4);

    // Flush at occupancy 2 with an incoming beat, then at occupancy 1 with an accept
    p0 = n_pop;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_in = '0;
      p_in.result = 16'hA1 + 16'(i);
      p_in.data_write = 1'b1;
      in_valid = 1'b1;
      tick(acc);
    end
    p_in.result = 16'hA3;
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush2_valid", out_valid, 0);
    chk("flush2_data_write", data_write, 0);
    chk("flush2_in_ready", in_ready, 1);
    p_in.result = 16'hB1;
    in_valid = 1'b1;
    tick(acc);
    p_in.result = 16'hB2;
    flush = 1'b1;
    tick(acc);
    chk("flush1_accepted", acc, 1);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush1_valid", out_valid, 0);
    chk("flush1_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick(acc);
    chk("flush_no_leak", n_pop - p0, 0);

    // Saturation, then asynchronous reset between active edges
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    out_ready = 1'b0;
    p_in = '0;
    p_in.result = 16'h0777;
    in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick(acc);
    chk("sat_cnt3", s_stall_cnt, 7);
    chk("sat_cnt8", stall_cnt, 10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_sat_stall_cnt", s_stall_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_result", result, 0);
    tick(acc);
    rst = 1'b0;
    tick(acc);

    // Randomized traffic
    acc = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        p_in = pay_t'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick(acc);
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick(acc);
    chk("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
